// File: rtl/rx_pkt_ctrl_pkg.sv
// rx_pkt_pkg: shared state/error types and PID constants for the USB receive controller
package rx_pkt_pkg;
  typedef enum logic [3:0] {IDLE, SYNC, PID, TOK1, TOK2, DATA, WRITE, EOP_WAIT, DONE, ERR, ERR_EOP} state_t;
  typedef enum logic [2:0] {E_NONE, E_SYNC, E_PID, E_ADDR, E_EP, E_OVF, E_EARLY, E_TRAIL} err_t;
  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
endpackage

// File: rtl/rx_pkt_ctrl_if.sv
// rx_pkt_ctrl_if: bus between the RX front end / FIFO and the receive controller
// line side: d_edge, eop, shift_enable, byte_received, rx_data, buff_full
// status side: rcving, w_enable, flush, r_error, err_code, pid, ep_num, data_len, data_ready
interface rx_pkt_ctrl_if #(parameter int CNT_W = 7);
  logic d_edge, eop, shift_enable, byte_received, buff_full;
  logic [7:0] rx_data;
  logic rcving, w_enable, flush, r_error, data_ready;
  logic [2:0] err_code;
  logic [3:0] pid, ep_num;
  logic [CNT_W-1:0] data_len;
  modport master(
    output d_edge, eop, shift_enable, byte_received, rx_data, buff_full,
    input rcving, w_enable, flush, r_error, err_code, pid, ep_num, data_len, data_ready
  );
  modport slave(
    input d_edge, eop, shift_enable, byte_received, rx_data, buff_full,
    output rcving, w_enable, flush, r_error, err_code, pid, ep_num, data_len, data_ready
  );
endinterface

// File: rtl/rx_pkt_ctrl_pid_decode.sv
// rx_pid_decode: classifies a PID byte; all flags are low when the complement check fails
// in: rx_data  out: pid_valid (known PID), is_token, is_data, is_hs
module rx_pid_decode import rx_pkt_pkg::*; (
  input  logic [7:0] rx_data,
  output logic       pid_valid,
  output logic       is_token,
  output logic       is_data,
  output logic       is_hs
);
  logic [3:0] p;
  logic ok;
  assign p = rx_data[3:0];
  assign ok = rx_data[7:4] == ~p;
  assign is_token = ok && (p == PID_OUT || p == PID_IN || p == PID_SETUP);
  assign is_data = ok && (p == PID_DATA0 || p == PID_DATA1);
  assign is_hs = ok && (p == PID_ACK || p == PID_NAK || p == PID_STALL);
  assign pid_valid = is_token | is_data | is_hs;
endmodule

// File: rtl/rx_pkt_ctrl.sv
// rx_pkt_ctrl: USB receive FSM with address/endpoint filtering, payload count and error codes
// ports: clk, n_rst (async active-low), bus (rx_pkt_ctrl_if.slave)
module rx_pkt_ctrl import rx_pkt_pkg::*; #(
  parameter logic [6:0] DEV_ADDR = 7'd0,
  parameter int NUM_EP = 1,
  parameter int MAX_DATA = 64,
  parameter int CNT_W = 7
) (
  input logic clk,
  input logic n_rst,
  rx_pkt_ctrl_if.slave bus
);
  state_t state, state_n;
  err_t err_n;
  logic [CNT_W-1:0] cnt;
  logic [3:0] endp;
  logic ep0, pid_valid, is_token, is_data, is_hs, eop_se, byte_rx;
  assign eop_se = bus.eop & bus.shift_enable;
  assign byte_rx = bus.byte_received;
  assign endp = {bus.rx_data[2:0], ep0};
  assign bus.rcving = state != IDLE;
  rx_pid_decode u_dec (.rx_data(bus.rx_data), .pid_valid, .is_token, .is_data, .is_hs);
  always_comb begin
    state_n = state;
    err_n = E_NONE;
    case (state)
      IDLE: state_n = bus.d_edge ? SYNC : IDLE;
      SYNC:
        if (byte_rx) begin
          state_n = bus.rx_data == SYNC_BYTE ? PID : ERR;
          err_n = bus.rx_data == SYNC_BYTE ? E_NONE : E_SYNC;
        end else if (eop_se) begin
          state_n = ERR;
          err_n = E_EARLY;
        end
      PID:
        if (byte_rx) begin
          state_n = !pid_valid ? ERR : is_token ? TOK1 : is_data ? DATA : EOP_WAIT;
          err_n = pid_valid ? E_NONE : E_PID;
        end
      TOK1:
        if (byte_rx) begin
          state_n = bus.rx_data[6:0] == DEV_ADDR ? TOK2 : ERR;
          err_n = bus.rx_data[6:0] == DEV_ADDR ? E_NONE : E_ADDR;
        end
      TOK2:
        if (byte_rx) begin
          state_n = {1'b0, endp} >= 5'(NUM_EP) ? ERR : EOP_WAIT;
          err_n = {1'b0, endp} >= 5'(NUM_EP) ? E_EP : E_NONE;
        end
      // a byte beyond payload+CRC, or one arriving while the FIFO is full, is dropped unwritten
      DATA:
        if (byte_rx) begin
          state_n = (bus.buff_full || cnt == CNT_W'(MAX_DATA + 2)) ? ERR : WRITE;
          err_n = (bus.buff_full || cnt == CNT_W'(MAX_DATA + 2)) ? E_OVF : E_NONE;
        end else if (eop_se) begin
          state_n = cnt < CNT_W'(2) ? ERR_EOP : DONE;
          err_n = cnt < CNT_W'(2) ? E_EARLY : E_NONE;
        end
      // EOP coinciding with the last byte is picked up on the next DATA cycle
      WRITE: state_n = DATA;
      EOP_WAIT:
        if (eop_se) state_n = DONE;
        else if (byte_rx) begin
          state_n = ERR;
          err_n = E_TRAIL;
        end
      DONE: state_n = IDLE;
      ERR: state_n = eop_se ? ERR_EOP : ERR;
      ERR_EOP: state_n = eop_se ? IDLE : ERR_EOP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state <= IDLE;
      cnt <= '0;
      ep0 <= 1'b0;
      bus.w_enable <= 1'b0;
      bus.flush <= 1'b0;
      bus.r_error <= 1'b0;
      bus.err_code <= '0;
      bus.pid <= '0;
      bus.ep_num <= '0;
      bus.data_len <= '0;
      bus.data_ready <= 1'b0;
    end else begin
      state <= state_n;
      bus.flush <= state == IDLE && bus.d_edge;
      bus.w_enable <= state_n == WRITE;
      bus.data_ready <= state_n == DONE && (bus.pid == PID_DATA0 || bus.pid == PID_DATA1);
      cnt <= state == PID ? '0 : state == WRITE ? cnt + 1'b1 : cnt;
      if (state == TOK1 && byte_rx) ep0 <= bus.rx_data[7];
      if (state == PID && byte_rx && pid_valid) bus.pid <= bus.rx_data[3:0];
      if (state == TOK2 && state_n == EOP_WAIT) bus.ep_num <= endp;
      if (state == DATA && state_n == DONE) bus.data_len <= cnt - CNT_W'(2);
      // error status survives the packet and is cleared only when the next one starts
      if (state == IDLE && bus.d_edge) begin
        bus.r_error <= 1'b0;
        bus.err_code <= E_NONE;
      end else if (err_n != E_NONE && !bus.r_error) begin
        bus.r_error <= 1'b1;
        bus.err_code <= err_n;
      end
    end
endmodule

// File: tb/tb_rx_pkt_ctrl.sv
// tb_rx_pkt_ctrl: table-driven packet vectors plus directed corner sequences
module tb_rx_pkt_ctrl;
  typedef struct {
    logic [79:0] b;
    int n;
    logic full;
    int rerr, code, pid, ep, w, rdy, len;
  } vec_t;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int errors = 0, checks = 0, wtot = 0, rtot = 0, ftot = 0;
  int w0, r0, f0;
  vec_t tbl [14];
  rx_pkt_ctrl_if #(.CNT_W(4)) bus ();
  rx_pkt_ctrl #(.DEV_ADDR(7'd5), .NUM_EP(2), .MAX_DATA(4), .CNT_W(4)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    wtot += int'(bus.w_enable);
    rtot += int'(bus.data_ready);
    ftot += int'(bus.flush);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic start();
    bus.d_edge = 1'b1;
    @(negedge clk);
    bus.d_edge = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.byte_received = 1'b1;
    @(negedge clk);
    bus.byte_received = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic send_eop();
    bus.eop = 1'b1;
    bus.shift_enable = 1'b1;
    @(negedge clk);
    bus.shift_enable = 1'b0;
    @(negedge clk);
    bus.shift_enable = 1'b1;
    @(negedge clk);
    bus.eop = 1'b0;
    bus.shift_enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    //            bytes (first on wire = MSB)   n  full rerr code pid ep  w rdy len
    tbl[0]  = '{80'h80C3112233A55A,           7, 0, 0, 0, 3,  0, 5, 1, 3};
    tbl[1]  = '{80'h80E10500,                 4, 0, 0, 0, 1,  0, 0, 0, 3};
    tbl[2]  = '{80'h80698500,                 4, 0, 0, 0, 9,  1, 0, 0, 3};
    tbl[3]  = '{80'h80E10600,                 4, 0, 1, 3, 1,  1, 0, 0, 3};
    tbl[4]  = '{80'h80E18501,                 4, 0, 1, 4, 1,  1, 0, 0, 3};
    tbl[5]  = '{80'h8033,                     2, 0, 1, 2, 1,  1, 0, 0, 3};
    tbl[6]  = '{80'h81,                       1, 0, 1, 1, 1,  1, 0, 0, 3};
    tbl[7]  = '{80'h804B01020304050607,       9, 0, 1, 5, 11, 1, 6, 0, 3};
    tbl[8]  = '{80'h804BAABBCC,               5, 0, 0, 0, 11, 1, 3, 1, 1};
    tbl[9]  = '{80'h80C311,                   3, 1, 1, 5, 3,  1, 0, 0, 1};
    tbl[10] = '{80'h80C311,                   3, 0, 1, 6, 3,  1, 1, 0, 1};
    tbl[11] = '{80'h80D2,                     2, 0, 0, 0, 2,  1, 0, 0, 1};
    tbl[12] = '{80'h80D200,                   3, 0, 1, 7, 2,  1, 0, 0, 1};
    tbl[13] = '{80'h80F0,                     2, 0, 1, 2, 2,  1, 0, 0, 1};
    bus.d_edge = 1'b0;
    bus.eop = 1'b0;
    bus.shift_enable = 1'b0;
    bus.byte_received = 1'b0;
    bus.rx_data = 8'h00;
    bus.buff_full = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst rcving", bus.rcving, 0);
    chk("rst w_enable", bus.w_enable, 0);
    chk("rst flush", bus.flush, 0);
    chk("rst r_error", bus.r_error, 0);
    chk("rst err_code", bus.err_code, 0);
    chk("rst pid", bus.pid, 0);
    chk("rst ep_num", bus.ep_num, 0);
    chk("rst data_len", bus.data_len, 0);
    chk("rst data_ready", bus.data_ready, 0);
    n_rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      w0 = wtot;
      r0 = rtot;
      f0 = ftot;
      bus.buff_full = tbl[i].full;
      start();
      for (int k = 0; k < tbl[i].n; k++) send_byte(tbl[i].b[8*(tbl[i].n-1-k) +: 8]);
      send_eop();
      bus.buff_full = 1'b0;
      chk($sformatf("v%0d r_error", i), bus.r_error, tbl[i].rerr);
      chk($sformatf("v%0d err_code", i), bus.err_code, tbl[i].code);
      chk($sformatf("v%0d pid", i), bus.pid, tbl[i].pid);
      chk($sformatf("v%0d ep_num", i), bus.ep_num, tbl[i].ep);
      chk($sformatf("v%0d writes", i), wtot - w0, tbl[i].w);
      chk($sformatf("v%0d data_ready", i), rtot - r0, tbl[i].rdy);
      chk($sformatf("v%0d data_len", i), bus.data_len, tbl[i].len);
      chk($sformatf("v%0d flush", i), ftot - f0, 1);
      chk($sformatf("v%0d rcving", i), bus.rcving, 0);
    end
    repeat (5) @(negedge clk);
    chk("hold r_error", bus.r_error, 1);
    chk("hold err_code", bus.err_code, 2);
    w0 = wtot;
    r0 = rtot;
    start();
    chk("clr r_error", bus.r_error, 0);
    chk("clr err_code", bus.err_code, 0);
    chk("clr flush", bus.flush, 1);
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'h11);
    send_byte(8'h22);
    bus.rx_data = 8'h33;
    bus.byte_received = 1'b1;
    bus.eop = 1'b1;
    bus.shift_enable = 1'b1;
    @(negedge clk);
    bus.byte_received = 1'b0;
    bus.shift_enable = 1'b0;
    @(negedge clk);
    bus.shift_enable = 1'b1;
    @(negedge clk);
    bus.eop = 1'b0;
    bus.shift_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("wr+eop writes", wtot - w0, 3);
    chk("wr+eop data_len", bus.data_len, 1);
    chk("wr+eop data_ready", rtot - r0, 1);
    chk("wr+eop r_error", bus.r_error, 0);
    w0 = wtot;
    r0 = rtot;
    start();
    send_byte(8'h80);
    send_byte(8'hC3);
    send_byte(8'h11);
    chk("mid rcving", bus.rcving, 1);
    n_rst = 1'b0;
    #1;
    chk("mrst rcving", bus.rcving, 0);
    chk("mrst pid", bus.pid, 0);
    chk("mrst ep_num", bus.ep_num, 0);
    chk("mrst data_len", bus.data_len, 0);
    chk("mrst w_enable", bus.w_enable, 0);
    chk("mrst flush", bus.flush, 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mrst idle", bus.rcving, 0);
    chk("mrst writes", wtot - w0, 1);
    chk("mrst data_ready", rtot - r0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rx_pkt_ctrl.md
Name: rx_pkt_ctrl

Overview:
Parametrised second-generation USB receive control FSM. It sits between the RX shift register/edge/EOP detectors and the RX FIFO, and decodes SYNC, PID (with complement check), token address/endpoint, and DATA payloads up to a configurable length. Beyond the first-generation block, it adds address/endpoint filtering, a payload length count, an overflow limit, and encoded error reporting.

Parameters:
DEV_ADDR, 7'd0, device address accepted in token packets
NUM_EP, 1, endpoints 0..NUM_EP-1 accepted (1..16)
MAX_DATA, 64, max DATA payload bytes, excluding the 2 CRC16 bytes
CNT_W, 7, width of byte counter; must satisfy 2^CNT_W > MAX_DATA+2

Ports:
clk  in  1  system clock
n_rst  in  1  async active-low reset
d_edge  in  1  line transition detected
eop  in  1  EOP condition on line
shift_enable  in  1  bit-period strobe
byte_received  in  1  one-cycle pulse, rx_data valid
rx_data  in  8  received byte, bit0 = first bit on wire
buff_full  in  1  RX FIFO full
rcving  out  1  packet in progress
w_enable  out  1  FIFO write strobe, one cycle per byte
flush  out  1  one-cycle FIFO flush at packet start
r_error  out  1  packet error flag
err_code  out  3  error cause
pid  out  4  decoded PID[3:0] of current/last packet
ep_num  out  4  endpoint from last accepted token
data_len  out  CNT_W  payload bytes of last good DATA packet
data_ready  out  1  one-cycle pulse, good DATA packet complete

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (n_rst). All outputs are registered except rcving, and all reset to 0.
- States: IDLE, SYNC, PID, TOK1, TOK2, DATA, WRITE, EOP_WAIT, DONE, ERR, ERR_EOP.
- IDLE: on d_edge -> SYNC. flush=1 for 1 cycle. r_error and err_code are cleared.
- SYNC: on byte_received: rx_data==8'h80 -> PID; otherwise err 1 (bad sync) -> ERR. On eop&&shift_enable -> ERR, err 6 (early EOP).
- PID: on byte_received: if rx_data[7:4] != ~rx_data[3:0], err 2 -> ERR. Otherwise latch pid=rx_data[3:0], then:
  - OUT/IN/SETUP (0001/1001/1101) -> TOK1.
  - DATA0/DATA1 (0011/1011) -> DATA, byte count cleared.
  - ACK/NAK/STALL (0010/1010/1110) -> EOP_WAIT.
  - Any other PID: err 2 -> ERR.
- TOK1: on byte_received: rx_data[6:0] != DEV_ADDR -> err 3 -> ERR. Otherwise hold rx_data[7] as endp bit0 -> TOK2.
- TOK2: on byte_received: endp = {rx_data[2:0], bit0}. If endp >= NUM_EP -> err 4 -> ERR. Otherwise ep_num <= endp -> EOP_WAIT. CRC5 is not checked.
- DATA: on byte_received -> WRITE.
  - In WRITE, w_enable=1 for exactly 1 cycle, count++, then back to DATA.
  - If count reaches MAX_DATA+2 and another byte arrives: err 5 (overflow) -> ERR, with no write.
  - If buff_full when a byte arrives: err 5 -> ERR.
  - On eop&&shift_enable: count < 2 -> err 6 -> ERR_EOP. Otherwise data_len <= count-2 -> DONE.
- WRITE: if byte_received and eop&&shift_enable occur in the same cycle, the write completes first and EOP is evaluated in the next DATA cycle. eop stays asserted for 2 bit times, so it is still seen.
- EOP_WAIT: eop&&shift_enable -> DONE. !eop&&shift_enable after a full byte (byte_received) -> err 7 (trailing data) -> ERR.
- DONE: data_ready=1 for 1 cycle only if the PID was DATA0/1 -> IDLE.
- ERR: r_error=1, holds until eop&&shift_enable -> ERR_EOP.
- ERR_EOP: eop&&shift_enable -> IDLE. r_error and err_code hold until the next d_edge in IDLE.
- err_code values: 0 none, 1 bad sync, 2 bad PID, 3 address mismatch, 4 bad endpoint, 5 overflow/full, 6 early EOP, 7 trailing data. The first error is latched; later errors in the same packet do not overwrite it.
- rcving = (state != IDLE), combinational.
- pid and ep_num hold until the next valid PID or token. They are not cleared in IDLE.
- Reset mid-packet: immediate return to IDLE, all outputs 0, no write or data_ready.

Decomposition:
- Package rx_pkt_pkg holds:
  - state enum typedef
  - PID nibble constants: PID_OUT, PID_IN, PID_SETUP, PID_DATA0, PID_DATA1, PID_ACK, PID_NAK, PID_STALL
  - SYNC_BYTE = 8'h80
  - err_code enum
- Sub-module rx_pid_decode: combinational; takes rx_data and outputs pid_valid, is_token, is_data, is_hs. Everything else stays in one module.

Test Plan:
- DATA0 packet: SYNC 80, PID C3, 3 payload bytes, 2 CRC bytes, EOP -> 5 w_enable pulses, data_len=3, data_ready one cycle, r_error=0, pid=0011.
- OUT token to DEV_ADDR=5, ep 0: bytes 80, E1, 05, xx, EOP -> ep_num=0, no writes, no data_ready, err_code=0.
- Token with addr 6 when DEV_ADDR=5 -> r_error=1, err_code=3, held through EOP until the next d_edge, ep_num unchanged.
- PID byte 0x33 (check fails) -> err_code=2. Also SYNC byte 0x81 -> err_code=1.
- MAX_DATA=4 with 7 bytes sent -> exactly 6 writes, err_code=5 on byte 7. A following good packet clears r_error.
- Data packet with EOP after 1 byte -> err_code=6. Assert n_rst during DATA -> all outputs 0 next sample, state IDLE.
